// File: rtl/wfq_rank_calc_param.sv
// WFQ rank calculator: per-flow virtual finish round, emitted as {class, port_id, finish}.
// Latency: descriptor in at T, rank out at T+2; CPU response at T+1. No backpressure, one descriptor per cycle.
module wfq_rank_calc_param #(
  parameter int NUM_PORTS      = 5,
  parameter int PORT_ID_WIDTH  = 3,
  parameter int PORT_WIDTH     = 8,
  parameter int CLASS_WIDTH    = 5,
  parameter int PKT_SIZE_WIDTH = 11,
  parameter int ROUND_WIDTH    = 20,
  parameter int WEIGHT_WIDTH   = 4,
  parameter int WEIGHT_MODE    = 0,
  parameter int CPU_IDX_WIDTH  = PORT_ID_WIDTH + CLASS_WIDTH,
  parameter int RANK_WIDTH     = CLASS_WIDTH + PORT_ID_WIDTH + ROUND_WIDTH
) (
  input  logic                                     clk_dp,
  input  logic                                     rst,
  input  logic                                     in_valid,
  input  logic [PORT_WIDTH+CLASS_WIDTH+PKT_SIZE_WIDTH-1:0] in_data,
  input  logic [NUM_PORTS*ROUND_WIDTH-1:0]         last_round,
  output logic                                     out_valid,
  output logic [RANK_WIDTH-1:0]                    out_rank,
  input  logic                                     cpu_valid,
  input  logic [1:0]                               cpu_op,
  input  logic [CPU_IDX_WIDTH-1:0]                 cpu_index,
  input  logic [WEIGHT_WIDTH-1:0]                  cpu_wdata,
  output logic                                     cpu_rvalid,
  output logic [ROUND_WIDTH+WEIGHT_WIDTH-1:0]      cpu_rdata
);
  localparam int NUM_CLASSES = 2 ** CLASS_WIDTH;
  localparam int NUM_FLOWS   = NUM_PORTS * NUM_CLASSES;
  localparam int FIN_WIDTH   = ROUND_WIDTH + PKT_SIZE_WIDTH + 2 ** WEIGHT_WIDTH;
  localparam logic [ROUND_WIDTH-1:0]   ROUND_MAX = '1;
  localparam logic [PORT_ID_WIDTH:0]   NP        = (PORT_ID_WIDTH + 1)'(NUM_PORTS);

  logic [CLASS_WIDTH-1:0]    in_class;
  logic [PORT_WIDTH-1:0]     in_port;
  logic [PKT_SIZE_WIDTH-1:0] in_size;
  logic [PORT_ID_WIDTH-1:0]  in_port_id;

  logic                      s1_vld_q, s1_vld_d;
  logic [CPU_IDX_WIDTH-1:0]  s1_flow_q, s1_flow_d;
  logic [PKT_SIZE_WIDTH-1:0] s1_size_q, s1_size_d;
  logic [CLASS_WIDTH-1:0]    s1_class_q, s1_class_d;
  logic [PORT_ID_WIDTH-1:0]  s1_port_id_q, s1_port_id_d;

  logic [ROUND_WIDTH-1:0]    last_round_q [NUM_PORTS];
  logic [ROUND_WIDTH-1:0]    last_round_d [NUM_PORTS];
  logic [ROUND_WIDTH-1:0]    round_q [NUM_FLOWS];
  logic [ROUND_WIDTH-1:0]    round_d [NUM_FLOWS];
  logic [WEIGHT_WIDTH-1:0]   weight_q [NUM_FLOWS];
  logic [WEIGHT_WIDTH-1:0]   weight_d [NUM_FLOWS];

  logic                      out_valid_q, out_valid_d;
  logic [RANK_WIDTH-1:0]     out_rank_q, out_rank_d;
  logic                      cpu_rvalid_q, cpu_rvalid_d;
  logic [ROUND_WIDTH+WEIGHT_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;

  logic [ROUND_WIDTH-1:0]    cur_round, cur_lr, start_round, fin;
  logic [WEIGHT_WIDTH-1:0]   cur_weight;
  logic [FIN_WIDTH-1:0]      cost, fin_wide;
  logic [PORT_ID_WIDTH-1:0]  cpu_port_id;
  logic                      cpu_hit;

  assign in_class = in_data[CLASS_WIDTH-1:0];
  assign in_port  = in_data[CLASS_WIDTH +: PORT_WIDTH];
  assign in_size  = in_data[CLASS_WIDTH+PORT_WIDTH +: PKT_SIZE_WIDTH];

  // Ports sit on even bit positions; anything else falls to the CPU/default port.
  always_comb begin
    in_port_id = PORT_ID_WIDTH'(NUM_PORTS - 1);
    for (int p = 0; p < NUM_PORTS - 1; p++) begin
      if ((2 * p < PORT_WIDTH) && (in_port == (PORT_WIDTH'(1) << (2 * p))))
        in_port_id = PORT_ID_WIDTH'(p);
    end
  end

  always_comb begin
    s1_vld_d     = in_valid;
    s1_flow_d    = {in_port_id, in_class};
    s1_size_d    = in_size;
    s1_class_d   = in_class;
    s1_port_id_d = in_port_id;
    for (int p = 0; p < NUM_PORTS; p++)
      last_round_d[p] = last_round[p*ROUND_WIDTH +: ROUND_WIDTH];
  end

  // S2: table read and finish computation; the write-back at the end of this
  // cycle is visible to the next descriptor without forwarding.
  always_comb begin
    cur_round   = round_q[s1_flow_q];
    cur_weight  = weight_q[s1_flow_q];
    cur_lr      = last_round_q[s1_port_id_q];
    start_round = (cur_round > cur_lr) ? cur_round : cur_lr;
    if (WEIGHT_MODE == 0) begin
      cost = FIN_WIDTH'(s1_size_q) << cur_weight;
    end else begin
      cost = FIN_WIDTH'(s1_size_q) >> cur_weight;
      if ((s1_size_q != '0) && (cost == '0))
        cost = FIN_WIDTH'(1);
    end
    fin_wide = FIN_WIDTH'(start_round) + cost;
    fin      = (fin_wide > FIN_WIDTH'(ROUND_MAX)) ? ROUND_MAX : fin_wide[ROUND_WIDTH-1:0];
  end

  assign cpu_port_id = cpu_index[CPU_IDX_WIDTH-1 -: PORT_ID_WIDTH];
  assign cpu_hit     = cpu_valid && ({1'b0, cpu_port_id} < NP);

  always_comb begin
    round_d      = round_q;
    weight_d     = weight_q;
    out_valid_d  = s1_vld_q;
    out_rank_d   = out_rank_q;
    cpu_rvalid_d = cpu_valid;
    cpu_rdata_d  = '0;
    if (s1_vld_q) begin
      round_d[s1_flow_q] = fin;
      out_rank_d         = {s1_class_q, s1_port_id_q, fin};
    end
    if (cpu_hit) begin
      cpu_rdata_d = {round_q[cpu_index], weight_q[cpu_index]};
      if (cpu_op == 2'b01)
        weight_d[cpu_index] = cpu_wdata;
      // Applied after the datapath write so a coincident clear wins.
      if (cpu_op == 2'b10)
        round_d[cpu_index] = '0;
    end
  end

  always_ff @(posedge clk_dp or negedge rst) begin
    if (!rst) begin
      s1_vld_q     <= 1'b0;
      s1_flow_q    <= '0;
      s1_size_q    <= '0;
      s1_class_q   <= '0;
      s1_port_id_q <= '0;
      out_valid_q  <= 1'b0;
      out_rank_q   <= '0;
      cpu_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      for (int p = 0; p < NUM_PORTS; p++)
        last_round_q[p] <= '0;
      for (int f = 0; f < NUM_FLOWS; f++) begin
        round_q[f]  <= '0;
        weight_q[f] <= '0;
      end
    end else begin
      s1_vld_q     <= s1_vld_d;
      s1_flow_q    <= s1_flow_d;
      s1_size_q    <= s1_size_d;
      s1_class_q   <= s1_class_d;
      s1_port_id_q <= s1_port_id_d;
      out_valid_q  <= out_valid_d;
      out_rank_q   <= out_rank_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      last_round_q <= last_round_d;
      round_q      <= round_d;
      weight_q     <= weight_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_rank   = out_rank_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
endmodule

// File: tb/tb_wfq_rank_calc_param.sv
// Scoreboarded bench for wfq_rank_calc_param: weight mode 0 instance plus a mode 1 instance.
module tb_wfq_rank_calc_param;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid0 = 1'b0, in_valid1 = 1'b0;
  logic [23:0] in_data = '0;
  logic [99:0] last_round = '0;
  logic        cpu_valid0 = 1'b0, cpu_valid1 = 1'b0;
  logic [1:0]  cpu_op = '0;
  logic [7:0]  cpu_index = '0;
  logic [3:0]  cpu_wdata = '0;

  logic        out_valid0, out_valid1, cpu_rvalid0, cpu_rvalid1;
  logic [27:0] out_rank0, out_rank1;
  logic [23:0] cpu_rdata0, cpu_rdata1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [63:0] val;
    int          cyc;
  } exp_t;

  exp_t qr0[$], qc0[$], qr1[$], qc1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wfq_rank_calc_param dut0 (
    .clk_dp(clk), .rst(rst), .in_valid(in_valid0), .in_data(in_data),
    .last_round(last_round), .out_valid(out_valid0), .out_rank(out_rank0),
    .cpu_valid(cpu_valid0), .cpu_op(cpu_op), .cpu_index(cpu_index),
    .cpu_wdata(cpu_wdata), .cpu_rvalid(cpu_rvalid0), .cpu_rdata(cpu_rdata0)
  );

  wfq_rank_calc_param #(.WEIGHT_MODE(1)) dut1 (
    .clk_dp(clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data),
    .last_round(last_round), .out_valid(out_valid1), .out_rank(out_rank1),
    .cpu_valid(cpu_valid1), .cpu_op(cpu_op), .cpu_index(cpu_index),
    .cpu_wdata(cpu_wdata), .cpu_rvalid(cpu_rvalid1), .cpu_rdata(cpu_rdata1)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic issue_pkt(input bit d, input logic [7:0] port, input logic [4:0] cls,
                           input logic [10:0] sz, input logic [2:0] pid, input logic [19:0] fin);
    exp_t e;
    in_data = {sz, port, cls};
    e.val   = 64'({cls, pid, fin});
    e.cyc   = cyc + 2;
    if (d) begin in_valid1 = 1'b1; qr1.push_back(e); end
    else   begin in_valid0 = 1'b1; qr0.push_back(e); end
  endtask

  task automatic send(input bit d, input logic [7:0] port, input logic [4:0] cls,
                      input logic [10:0] sz, input logic [2:0] pid, input logic [19:0] fin);
    issue_pkt(d, port, cls, sz, pid, fin);
    tick();
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
  endtask

  task automatic issue_cpu(input bit d, input logic [1:0] op, input logic [7:0] idx,
                           input logic [3:0] wd, input logic [19:0] er, input logic [3:0] ew);
    exp_t e;
    cpu_op    = op;
    cpu_index = idx;
    cpu_wdata = wd;
    e.val     = 64'({er, ew});
    e.cyc     = cyc + 1;
    if (d) begin cpu_valid1 = 1'b1; qc1.push_back(e); end
    else   begin cpu_valid0 = 1'b1; qc0.push_back(e); end
  endtask

  task automatic cpu(input bit d, input logic [1:0] op, input logic [7:0] idx,
                     input logic [3:0] wd, input logic [19:0] er, input logic [3:0] ew);
    issue_cpu(d, op, idx, wd, er, ew);
    tick();
    cpu_valid0 = 1'b0;
    cpu_valid1 = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (out_valid0) begin
      if (qr0.size() == 0) chk("rank0_unexpected", 64'(out_rank0), 64'hDEAD_0000_0000_0000);
      else begin
        e = qr0.pop_front();
        chk("rank0", 64'(out_rank0), e.val);
        chk("rank0_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (cpu_rvalid0) begin
      if (qc0.size() == 0) chk("cpu0_unexpected", 64'(cpu_rdata0), 64'hDEAD_0000_0000_0000);
      else begin
        e = qc0.pop_front();
        chk("cpu0", 64'(cpu_rdata0), e.val);
        chk("cpu0_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (out_valid1) begin
      if (qr1.size() == 0) chk("rank1_unexpected", 64'(out_rank1), 64'hDEAD_0000_0000_0000);
      else begin
        e = qr1.pop_front();
        chk("rank1", 64'(out_rank1), e.val);
        chk("rank1_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (cpu_rvalid1) begin
      if (qc1.size() == 0) chk("cpu1_unexpected", 64'(cpu_rdata1), 64'hDEAD_0000_0000_0000);
      else begin
        e = qc1.pop_front();
        chk("cpu1", 64'(cpu_rdata1), e.val);
        chk("cpu1_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid0"}, 64'(out_valid0), 64'd0);
    chk({tag, "_out_rank0"}, 64'(out_rank0), 64'd0);
    chk({tag, "_cpu_rvalid0"}, 64'(cpu_rvalid0), 64'd0);
    chk({tag, "_cpu_rdata0"}, 64'(cpu_rdata0), 64'd0);
    chk({tag, "_out_valid1"}, 64'(out_valid1), 64'd0);
    chk({tag, "_out_rank1"}, 64'(out_rank1), 64'd0);
  endtask

  initial begin
    idle(3);
    chk_reset_outputs("reset");
    rst = 1'b1;
    idle(2);

    // Basic packet and readback on flow {0,3}
    send(0, 8'h01, 5'd3, 11'd100, 3'd0, 20'd100);
    idle(2);
    cpu(0, 2'b00, 8'd3, 4'd0, 20'd100, 4'd0);

    // Weight 2 on flow {1,1}, then three back-to-back packets
    cpu(0, 2'b01, 8'd33, 4'd2, 20'd0, 4'd0);
    send(0, 8'h04, 5'd1, 11'd64, 3'd1, 20'd256);
    send(0, 8'h04, 5'd1, 11'd64, 3'd1, 20'd512);
    send(0, 8'h04, 5'd1, 11'd64, 3'd1, 20'd768);
    idle(2);

    // Port 2: flow at 50, last_round raised to 500
    send(0, 8'h10, 5'd0, 11'd50, 3'd2, 20'd50);
    idle(2);
    last_round[2*20 +: 20] = 20'd500;
    idle(2);
    send(0, 8'h10, 5'd0, 11'd10, 3'd2, 20'd510);
    send(0, 8'h10, 5'd0, 11'd10, 3'd2, 20'd520);
    idle(2);

    // Non-matching port fields go to the default port
    send(0, 8'h03, 5'd0, 11'd5, 3'd4, 20'd5);
    send(0, 8'h00, 5'd0, 11'd7, 3'd4, 20'd12);
    send(0, 8'h80, 5'd0, 11'd1, 3'd4, 20'd13);

    // Saturation on flow {3,2}, then clear
    last_round[3*20 +: 20] = 20'hFFFF0;
    idle(2);
    send(0, 8'h40, 5'd2, 11'h100, 3'd3, 20'hFFFFF);
    send(0, 8'h40, 5'd2, 11'd1, 3'd3, 20'hFFFFF);
    idle(2);
    cpu(0, 2'b10, 8'd98, 4'd0, 20'hFFFFF, 4'd0);
    cpu(0, 2'b00, 8'd98, 4'd0, 20'd0, 4'd0);
    last_round = '0;
    idle(2);

    // Weight write coincident with S2 use: old weight (2) is used
    issue_pkt(0, 8'h04, 5'd1, 11'd1, 3'd1, 20'd772);
    tick();
    in_valid0 = 1'b0;
    issue_cpu(0, 2'b01, 8'd33, 4'd0, 20'd768, 4'd2);
    tick();
    cpu_valid0 = 1'b0;
    idle(2);
    send(0, 8'h04, 5'd1, 11'd1, 3'd1, 20'd773);
    idle(2);

    // Clear coincident with write-back on flow {0,3}: clear wins
    issue_pkt(0, 8'h01, 5'd3, 11'd20, 3'd0, 20'd120);
    tick();
    in_valid0 = 1'b0;
    issue_cpu(0, 2'b10, 8'd3, 4'd0, 20'd100, 4'd0);
    tick();
    cpu_valid0 = 1'b0;
    idle(2);
    cpu(0, 2'b00, 8'd3, 4'd0, 20'd0, 4'd0);

    // Out-of-range CPU index: ignored, data 0, response still given
    cpu(0, 2'b00, 8'd163, 4'd0, 20'd0, 4'd0);
    cpu(0, 2'b01, 8'hE0, 4'd7, 20'd0, 4'd0);

    // Weight mode 1 instance: minimum cost and shift-right cost
    cpu(1, 2'b01, 8'd0, 4'd4, 20'd0, 4'd0);
    send(1, 8'h01, 5'd0, 11'd8, 3'd0, 20'd1);
    send(1, 8'h01, 5'd0, 11'd64, 3'd0, 20'd5);
    send(1, 8'h01, 5'd0, 11'd0, 3'd0, 20'd5);
    idle(2);
    cpu(1, 2'b00, 8'd0, 4'd0, 20'd5, 4'd4);
    idle(2);

    // Reset with descriptors in flight: nothing may come out
    in_data   = {11'd9, 8'h01, 5'd3};
    in_valid0 = 1'b1;
    in_valid1 = 1'b1;
    tick();
    rst       = 1'b0;
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    idle(2);
    chk_reset_outputs("midreset");
    rst = 1'b1;
    idle(3);
    cpu(0, 2'b00, 8'd3, 4'd0, 20'd0, 4'd0);
    cpu(0, 2'b00, 8'd33, 4'd0, 20'd0, 4'd0);
    cpu(0, 2'b00, 8'd64, 4'd0, 20'd0, 4'd0);
    cpu(0, 2'b00, 8'd98, 4'd0, 20'd0, 4'd0);
    cpu(0, 2'b00, 8'd128, 4'd0, 20'd0, 4'd0);
    cpu(1, 2'b00, 8'd0, 4'd0, 20'd0, 4'd0);
    idle(4);

    chk("drain_rank0", 64'(qr0.size()), 64'd0);
    chk("drain_cpu0", 64'(qc0.size()), 64'd0);
    chk("drain_rank1", 64'(qr1.size()), 64'd0);
    chk("drain_cpu1", 64'(qc1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wfq_rank_calc_param.md
Name: wfq_rank_calc_param

Overview:
- Parametrised weighted-fair-queueing rank calculator for the PIFO scheduler path.
- Maps each packet to a flow (egress port × class) and computes its virtual finish round:
  - start = max(flow round, port's last dequeued round)
  - finish = start + weighted packet size
- Writes the finish round back into the flow table and emits {class, port_id, finish} as the PIFO rank.
- Generalises the earlier fixed-size calculator:
  - port/class/width counts are parameters
  - weight mode is selectable
  - arithmetic is saturating
  - CPU access has a single-clock op set: read, write weight, clear round.

Parameters:
- NUM_PORTS, 5, flow-table port count; the last index is the CPU/default port.
- PORT_ID_WIDTH, 3, ≥ clog2(NUM_PORTS).
- PORT_WIDTH, 8, width of the one-hot-style input port field.
- CLASS_WIDTH, 5, class field width; NUM_CLASSES = 2**CLASS_WIDTH.
- PKT_SIZE_WIDTH, 11, packet length width.
- ROUND_WIDTH, 20, virtual round width.
- WEIGHT_WIDTH, 4, per-flow weight (shift amount) width.
- WEIGHT_MODE, 0:
  - 0 = cost is size<<weight (larger weight → less bandwidth)
  - 1 = cost is size>>weight (larger weight → more bandwidth)
- CPU_IDX_WIDTH, PORT_ID_WIDTH+CLASS_WIDTH, flow index width = {port_id, class}.
- RANK_WIDTH, CLASS_WIDTH+PORT_ID_WIDTH+ROUND_WIDTH, output rank width.

Ports:
- clk_dp  in  1  single clock for datapath and CPU interface.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  packet descriptor valid.
- in_data  in  PORT_WIDTH+CLASS_WIDTH+PKT_SIZE_WIDTH  {pkt_size, port, class}, with class in the LSBs.
- last_round  in  NUM_PORTS*ROUND_WIDTH  per-port last dequeued round; port p occupies slice p.
- out_valid  out  1  rank valid.
- out_rank  out  RANK_WIDTH  {class, port_id, finish_round}.
- cpu_valid  in  1  CPU request strobe.
- cpu_op  in  2  00 read, 01 write weight, 10 clear round, 11 reserved (behaves as read).
- cpu_index  in  CPU_IDX_WIDTH  flow index.
- cpu_wdata  in  WEIGHT_WIDTH  weight to write.
- cpu_rvalid  out  1  response valid.
- cpu_rdata  out  ROUND_WIDTH+WEIGHT_WIDTH  {round, weight} of the indexed flow, sampled before the op takes effect.

Behaviour:
- Reset (rst=0, asynchronous):
  - out_valid=0, out_rank=0, cpu_rvalid=0, cpu_rdata=0.
  - All flow rounds=0, all weights=0, registered last_round=0, pipeline valids=0.
- last_round is registered every cycle, giving one cycle of skew.
- Port decode:
  - port_id=p when port == 1<<(2p), for p in 0..NUM_PORTS-2.
  - Any other value (including 0 and multi-hot) → NUM_PORTS-1.
  - flow = {port_id, class}.
- Pipeline; accepts one descriptor per cycle with no backpressure:
  - S1 (edge after in_valid): register flow, size, class, port_id, valid.
  - S2 (combinational on S1 regs): read round[flow], weight[flow], last_round[port_id].
  - S2 computes start = max(round, last_round[port_id]) and cost = size shifted by weight per WEIGHT_MODE.
  - S2 finish = start+cost, computed ROUND_WIDTH+PKT_SIZE_WIDTH+2^WEIGHT_WIDTH bits wide and saturated to all-ones of ROUND_WIDTH.
  - Edge after S2: round[flow]←finish, out_rank←{class, port_id, finish}, out_valid←1.
  - Latency: in_valid at cycle T → out_valid at T+2; out_valid is high for exactly one cycle per descriptor.
- Mode 1: if size>0 and size>>weight==0, cost=1, so a nonzero packet always advances the round.
- Back-to-back packets on the same flow: the table read is in S2 and the write lands at the end of S2, so packet N+1 sees packet N's finish with no bubble and no forwarding needed. This is mandatory.
- Saturated rounds stay saturated until cleared by CPU. There is no wrap-around.
- CPU interface:
  - cpu_valid at T → cpu_rvalid=1 at T+1 for one cycle, with cpu_rdata = pre-op value.
  - Write updates weight[cpu_index] at the T edge.
  - Clear sets round[cpu_index]=0 at the T edge.
- Simultaneous CPU clear and S2 write-back on the same flow: the clear wins and the round ends at 0. out_rank is still emitted with the computed finish.
- Simultaneous CPU weight write and S2 use on the same flow: S2 uses the old weight.
- cpu_index with port_id ≥ NUM_PORTS: the op is ignored and the response returns 0, still with cpu_rvalid=1.
- Reset asserted mid-operation clears all in-flight descriptors. No output is produced for them.

Test Plan:
- Reset, then in_valid with port=0x01, class=3, size=100, weight 0, last_round=0 → out_valid at T+2, out_rank={3,0,100}. A CPU read of index {0,3} returns {100,0}.
- Three back-to-back packets, port 0x04 class 1, size 64, weight 2 (mode 0) → finishes 256, 512, 768 on consecutive cycles.
- Flow round 50, last_round[2]=500, packet port 0x10 size 10 weight 0 → finish 510; next packet size 10 → 520.
- Port field 0x03 and 0x00 → port_id 4. Round 0xFFFF0 plus cost 0x100 → finish saturates to 0xFFFFF; a CPU clear then returns round 0.
- WEIGHT_MODE=1, weight 4, size 8 → cost 1 (minimum). Size 64 → cost 4.
- CPU clear on the same cycle as S2 write-back on the same flow → round reads back 0, out_rank carries the computed finish. Assert rst mid-stream → no out_valid for in-flight descriptors, and all tables read back 0.
